// File: rtl/aes_pkg.sv
// Shared AES types and helpers for the inverse-round datapath.
// Byte 0 of a state is its most significant byte.
package aes_pkg;

    typedef logic [7:0]   byte_t;
    typedef logic [127:0] state_t;

    localparam int NUM_BYTES = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_e;

    function automatic byte_t get_byte(input state_t s, input logic [3:0] idx);
        state_t shifted;
        shifted = s >> {(4'd15 - idx), 3'b000};
        return shifted[7:0];
    endfunction

endpackage

// File: rtl/inv_aes_s_table.sv
// Combinational AES inverse S-box addressed by {row, col} nibbles.
// The table is held as a constant array so synthesis can map it to LUTs or ROM.
module inv_aes_s_table
    import aes_pkg::*;
(
    input  logic [3:0] row_i,
    input  logic [3:0] col_i,
    output byte_t      sub_o
);

    localparam byte_t INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign sub_o = INV_SBOX[{row_i, col_i}];

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Inverse SubBytes over a 128-bit state using LANES shared S-box lookups per cycle.
// Accept in IDLE, substitute LANES bytes per RUN cycle, hold the result in DONE until taken.
module inv_sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   in_valid,
    output logic   in_ready,
    input  state_t in_data,
    output logic   out_valid,
    input  logic   out_ready,
    output state_t out_data,
    output logic   busy
);

    localparam int NSTEPS = NUM_BYTES / LANES;
    localparam int CW     = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
            $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    fsm_e            state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    state_t          work_q, work_d;
    state_t          result_q, result_d;

    logic [3:0]      lane_idx [LANES];
    byte_t           lane_sub [LANES];

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            byte_t src;
            assign lane_idx[gi] = 4'(int'(cnt_q) * LANES + gi);
            assign src          = get_byte(work_q, lane_idx[gi]);

            inv_aes_s_table u_sbox (
                .row_i (src[7:4]),
                .col_i (src[3:0]),
                .sub_o (lane_sub[gi])
            );
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        result_d = result_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = in_data;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Each lane owns one byte slot per step; the write is by constant slice.
                for (int k = 0; k < LANES; k++) begin
                    for (int b = 0; b < NUM_BYTES; b++) begin
                        if (lane_idx[k] == 4'(b)) begin
                            result_d[127-8*b -: 8] = lane_sub[k];
                        end
                    end
                end
                if (cnt_q == CW'(NSTEPS - 1)) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            work_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = result_q;

endmodule

// File: doc/inv_sub_bytes_seq.md
Name: inv_sub_bytes_seq

Overview:
Sequences the 128-bit AES decryption state through the inverse SubBytes step using a parameterised number of shared inverse S-box lookup lanes. Each lane performs one lookup per cycle, so 16 bytes take 16/LANES cycles. The block sits in the inverse-round datapath between InvShiftRows and AddRoundKey. Input and output use valid/ready handshakes.

Parameters:
LANES, 4, number of parallel inverse S-box lookups per cycle; legal values 1, 2, 4, 8, 16; any other value is an elaboration error.
NSTEPS, 16/LANES, derived local constant: number of RUN cycles per block.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous reset, active-high.
in_valid  input  1  in_data is valid.
in_ready  output  1  block can accept a state.
in_data  input  128  state; byte i = in_data[127-8i -: 8], byte 0 is the MSB.
out_valid  output  1  out_data holds a completed result.
out_ready  input  1  downstream accepts the result.
out_data  output  128  inverse-substituted state, same byte order as in_data.
busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst=1 at an edge): FSM goes to IDLE; step counter = 0; work and result registers = 0. While in IDLE after reset: in_ready=1, out_valid=0, busy=0, out_data=0. Reset overrides every other event, including a mid-RUN operation or a pending DONE result; the in-flight data is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. If in_valid=1 at an edge: capture in_data into the work register, clear the counter, go to RUN. No other action.
- RUN: in_ready=0, busy=1. Each cycle, lane k (0..LANES-1) looks up byte j = cnt*LANES + k. The lookup uses row = byte[7:4] and col = byte[3:0], and is combinational. The result byte j is written at the edge; cnt increments.
  - When cnt == NSTEPS-1 at an edge, go to DONE.
  - in_valid is ignored in RUN; the upstream holds its data.
- DONE: out_valid=1, in_ready=0, busy=1. out_data is stable until the handshake. On out_ready=1 at an edge, go to IDLE.
  - No bypass: a new input cannot be accepted in the same cycle as the output handshake. Throughput is one block per NSTEPS+2 cycles.
- Latency: if the input handshake completes at edge E, out_valid is first high in the cycle after edge E+NSTEPS. With LANES=4, that is 5 cycles after acceptance; with LANES=16, 2 cycles.
- out_data is driven only from the result register. It changes only at RUN writes and is never glitched by lookup logic.
- Counter width is clog2(NSTEPS), minimum 1 bit. It never wraps past NSTEPS-1. With LANES=16 it stays 0 and RUN lasts exactly one cycle.
- out_ready held high while not in DONE has no effect. in_valid dropping after acceptance has no effect.

Decomposition:
- Shared package aes_pkg holds:
  - byte_t (logic [7:0])
  - state_t (logic [127:0])
  - NUM_BYTES = 16
  - the fsm_e enum {IDLE, RUN, DONE}
  - a function get_byte(state_t, idx) implementing the MSB-first byte order
- Sub-module: instantiate the existing inv_aes_s_table LANES times in a generate loop. No new lookup module is written.
- The FSM, counter and byte-write logic live in inv_sub_bytes_seq.

Test Plan:
- Reset, then in_data = 0x637c777bf26b6fc53001672bfed7ab76 with in_valid=1 -> accepted in one cycle. After 5 cycles, out_valid=1 and out_data = 0x000102030405060708090a0b0c0d0e0f.
- in_data all bytes 0x00 -> out_data all 0x52. in_data all 0xff -> out_data all 0x7d. in_data all 0x16 -> out_data all 0xff.
- Backpressure: hold out_ready=0 for 10 cycles in DONE. out_valid and out_data stay stable and in_ready=0. Then out_ready=1 -> next cycle IDLE, in_ready=1, out_valid=0.
- Assert rst during the 2nd RUN cycle -> next cycle out_valid=0, in_ready=1, busy=0, out_data=0. A new input then completes normally with the correct result.
- in_valid held high through RUN and DONE with changing in_data -> only the first value is processed. The second value is accepted one cycle after the output handshake.
- Repeat the first scenario with LANES=1, 2, 8 and 16 -> identical out_data. Latency is NSTEPS+1 cycles (16, 8, 2 and 1 RUN cycles respectively).
